fetch_pc_sequencer: RTL and testbench
=====================================

// Module: fetch_pc_sequencer
// PURPOSE
//  Owns the program counter and instruction-fetch handshake; stage directly upstream of control_signal decode.
//  Fetches insn at pc from imem (variable latency), holds it valid for decode/execute until the core signals
//  completion, then resolves next PC from decoder pc_selector/pc_ctrl_ilt_neq, ALU flags and register values.
//  Also supplies pc_plus1 for jal writeback and a retired-instruction counter.
// PARAMETERS
//  PC_W    12  PC / imem address width (word addressed)
//  DATA_W  32  instruction and register data width
// PORTS
//  clock            in   1       system clock, all state on rising edge
//  reset            in   1       synchronous, active-high reset
//  imem_req         out  1       fetch request, high throughout S_FETCH
//  imem_addr        out  PC_W    fetch address (= pc), stable while imem_req high
//  imem_rdata       in   DATA_W  fetched word, sampled when imem_req & imem_ready
//  imem_ready       in   1       imem data valid this cycle
//  insn             out  DATA_W  registered current instruction
//  insn_valid       out  1       insn valid for decode/execute (high in S_EXEC)
//  exec_done        in   1       core finished insn; next-PC inputs valid this cycle
//  pc_selector      in   3       next-PC mode from control_signal
//  pc_ctrl_ilt_neq  in   1       1 = branch on not-equal (bne), 0 = on less-than (blt)
//  alu_isNotEqual   in   1       ALU compare: $rd != $rs
//  alu_isLessThan   in   1       ALU compare: $rd < $rs
//  rd_value         in   DATA_W  $rd read value (jr target)
//  rstatus_value    in   DATA_W  $r30 value (bex test)
//  pc               out  PC_W    current PC
//  pc_plus1         out  PC_W    pc+1 (combinational), jal link value
//  insn_count       out  32      retired instruction count
// BEHAVIOUR
//  Reset (clock edge with reset=1): state=S_IDLE, pc=0, insn=0, insn_valid=0, insn_count=0; imem_req=0.
//  States: S_IDLE -> S_FETCH unconditionally next cycle.
//   S_FETCH: imem_req=1, imem_addr=pc. On imem_ready: insn<=imem_rdata, insn_valid<=1, ->S_EXEC; else stay.
//   S_EXEC: insn_valid=1, insn held. On exec_done: pc<=next_pc, insn_valid<=0, insn_count<=+1, ->S_FETCH.
//  imem_ready outside S_FETCH and exec_done outside S_EXEC are ignored.
//  imem_ready may rise in the same cycle as imem_req; minimum period 2 cycles per instruction.
//  next_pc (all arithmetic mod 2^PC_W, wrap silent; T=insn[26:0] truncated to PC_W; N=sext(insn[16:0]) trunc):
//   3'b000 jump(j/jal): T | 3'b001 bex: (rstatus_value!=0) ? T : pc+1 | 3'b010 seq: pc+1
//   3'b011 branch: take = pc_ctrl_ilt_neq ? alu_isNotEqual : alu_isLessThan; take ? pc+1+N : pc+1
//   3'b101 jr: rd_value[PC_W-1:0] | 3'b100/110/111: pc+1 (undefined decode falls through)
//  pc changes only on exec_done in S_EXEC; pc_plus1 tracks pc combinationally.
//  insn_count wraps 0xFFFFFFFF -> 0.
//  Reset mid-operation (any state, including pending imem_ready/exec_done same cycle): reset wins, all to reset values.
// STRUCTURE
//  Shared header pc_sel_defs.vh: PCSEL_JUMP/BEX/SEQ/BRANCH/JR encodings (3'b000/001/010/011/101) and
//   state encodings S_IDLE/S_FETCH/S_EXEC; control_signal to adopt same defines.
//  One combinational sub-module next_pc_calc (pc, insn, selector, flags, rd/rstatus -> next_pc); sequencer FSM,
//   PC/insn registers and counter in this module.
// TESTING
//  Reset then imem_ready=1 every cycle: imem_req low cycle 0, imem_addr=0 first req, insn_valid one cycle later.
//  imem_ready delayed 5 cycles: imem_addr/imem_req stable 5 cycles, insn captures rdata only on ready cycle.
//  pc=10, branch, ilt_neq=1, isNotEqual=1, N=-3 -> pc=8; same with isNotEqual=0 -> pc=11; ilt_neq=0, isLessThan=1, N=4 -> pc=15.
//  pc=20, jump T=0x123 -> pc=0x123; bex rstatus=0 -> pc=21, rstatus=7 -> T; jr rd_value=0x1F00F -> pc=0x00F.
//  pc=0xFFF seq -> pc=0x000; insn_count preloaded path 0xFFFFFFFF -> 0 on retire.
//  Assert reset in S_EXEC with exec_done=1 same cycle -> pc=0, insn_valid=0, count=0, state S_IDLE.

Source files
------------

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: next-PC selector values and FSM states.
// Decode logic producing pc_selector uses these same encodings.
package fetch_pc_sequencer_pkg;

    typedef enum logic [2:0] {
        PcSelJump   = 3'b000,
        PcSelBex    = 3'b001,
        PcSelSeq    = 3'b010,
        PcSelBranch = 3'b011,
        PcSelJr     = 3'b101
    } pc_sel_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StExec  = 2'b10
    } state_e;

endpackage

// File: rtl/fetch_pc_sequencer_next_pc_calc.sv
// Combinational next-PC resolution from the current instruction, selector, ALU flags and registers.
// All arithmetic wraps modulo 2^PC_W.
module fetch_pc_sequencer_next_pc_calc
    import fetch_pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W   = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] insn_i,
    input  logic [2:0]        pc_sel_i,
    input  logic              ilt_neq_i,
    input  logic              is_not_equal_i,
    input  logic              is_less_than_i,
    input  logic [DATA_W-1:0] rd_value_i,
    input  logic [DATA_W-1:0] rstatus_value_i,
    output logic [PC_W-1:0]   next_pc_o
);

    logic [26:0]     target_full;
    logic [31:0]     offset_full;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] pc_plus1;
    logic            take;

    // Upper instruction/register bits play no part in PC resolution.
    logic unused_bits;
    assign unused_bits = ^{insn_i[DATA_W-1:27], rd_value_i[DATA_W-1:PC_W]};

    assign target_full = insn_i[26:0];
    assign offset_full = {{15{insn_i[16]}}, insn_i[16:0]};
    assign target      = target_full[PC_W-1:0];
    assign offset      = offset_full[PC_W-1:0];
    assign pc_plus1    = pc_i + PC_W'(1);
    assign take        = ilt_neq_i ? is_not_equal_i : is_less_than_i;

    // Select the next PC; undefined selector codes fall through to sequential.
    always_comb begin
        next_pc_o = pc_plus1;
        case (pc_sel_i)
            PcSelJump:   next_pc_o = target;
            PcSelBex:    next_pc_o = (rstatus_value_i != '0) ? target : pc_plus1;
            PcSelSeq:    next_pc_o = pc_plus1;
            PcSelBranch: next_pc_o = take ? (pc_plus1 + offset) : pc_plus1;
            PcSelJr:     next_pc_o = rd_value_i[PC_W-1:0];
            default:     next_pc_o = pc_plus1;
        endcase
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Program counter owner and instruction-fetch handshake. Fetches from a variable-latency imem,
// holds the instruction for decode/execute until exec_done, then advances the PC.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W   = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              imem_ready_i,
    output logic [DATA_W-1:0] insn_o,
    output logic              insn_valid_o,
    input  logic              exec_done_i,
    input  logic [2:0]        pc_selector_i,
    input  logic              pc_ctrl_ilt_neq_i,
    input  logic              alu_is_not_equal_i,
    input  logic              alu_is_less_than_i,
    input  logic [DATA_W-1:0] rd_value_i,
    input  logic [DATA_W-1:0] rstatus_value_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   pc_plus1_o,
    output logic [31:0]       insn_count_o
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] insn_q, insn_d;
    logic [31:0]       insn_count_q, insn_count_d;
    logic [PC_W-1:0]   next_pc;

    fetch_pc_sequencer_next_pc_calc #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_next_pc_calc (
        .pc_i            (pc_q),
        .insn_i          (insn_q),
        .pc_sel_i        (pc_selector_i),
        .ilt_neq_i       (pc_ctrl_ilt_neq_i),
        .is_not_equal_i  (alu_is_not_equal_i),
        .is_less_than_i  (alu_is_less_than_i),
        .rd_value_i      (rd_value_i),
        .rstatus_value_i (rstatus_value_i),
        .next_pc_o       (next_pc)
    );

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: idle always moves to fetch; fetch waits for imem; exec waits for the core.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (imem_ready_i) state_d = StExec;
            StExec:  if (exec_done_i) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        imem_req_o   = (state_q == StFetch);
        insn_valid_o = (state_q == StExec);
    end

    // Datapath next-state: capture insn on fetch completion, advance PC and count on retire.
    always_comb begin
        pc_d         = pc_q;
        insn_d       = insn_q;
        insn_count_d = insn_count_q;
        if (state_q == StFetch && imem_ready_i) begin
            insn_d = imem_rdata_i;
        end
        if (state_q == StExec && exec_done_i) begin
            pc_d         = next_pc;
            insn_count_d = insn_count_q + 32'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_q         <= '0;
            insn_q       <= '0;
            insn_count_q <= '0;
        end else begin
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            insn_count_q <= insn_count_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign insn_o       = insn_q;
    assign pc_o         = pc_q;
    assign pc_plus1_o   = pc_q + PC_W'(1);
    assign insn_count_o = insn_count_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed program plus randomized traffic,
// compared every cycle against a behavioural model.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] insn;
    logic        insn_valid;
    logic        exec_done = 1'b0;
    logic [2:0]  pc_sel = '0;
    logic        ilt_neq = 1'b0;
    logic        is_ne = 1'b0;
    logic        is_lt = 1'b0;
    logic [31:0] rd_value = '0;
    logic [31:0] rstatus_value = '0;
    logic [11:0] pc;
    logic [11:0] pc_plus1;
    logic [31:0] insn_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase 0 = idle, 1 = fetching, 2 = holding an instruction.
    int          m_phase = 0;
    logic [11:0] m_pc    = '0;
    logic [31:0] m_insn  = '0;
    logic [31:0] m_count = '0;

    fetch_pc_sequencer #(
        .PC_W   (12),
        .DATA_W (32)
    ) dut (
        .clock_i            (clk),
        .reset_i            (rst),
        .imem_req_o         (imem_req),
        .imem_addr_o        (imem_addr),
        .imem_rdata_i       (imem_rdata),
        .imem_ready_i       (imem_ready),
        .insn_o             (insn),
        .insn_valid_o       (insn_valid),
        .exec_done_i        (exec_done),
        .pc_selector_i      (pc_sel),
        .pc_ctrl_ilt_neq_i  (ilt_neq),
        .alu_is_not_equal_i (is_ne),
        .alu_is_less_than_i (is_lt),
        .rd_value_i         (rd_value),
        .rstatus_value_i    (rstatus_value),
        .pc_o               (pc),
        .pc_plus1_o         (pc_plus1),
        .insn_count_o       (insn_count)
    );

    always #5 clk = ~clk;

    function automatic int wrap12(input int x);
        return ((x % 4096) + 4096) % 4096;
    endfunction

    function automatic logic [11:0] ref_next_pc(input logic [11:0] cur, input logic [31:0] w,
                                                input logic [2:0] sel, input logic ilt,
                                                input logic ne, input logic lt,
                                                input logic [31:0] rd, input logic [31:0] rs);
        int p1;
        int t;
        int n;
        int r;
        logic take;
        p1 = wrap12(int'(cur) + 1);
        t  = int'(w[26:0]) % 4096;
        n  = int'(w[16:0]);
        if (w[16]) n = n - 131072;
        take = ilt ? ne : lt;
        case (sel)
            3'd0:    r = t;
            3'd1:    r = (rs != 0) ? t : p1;
            3'd3:    r = take ? wrap12(int'(cur) + 1 + n) : p1;
            3'd5:    r = int'(rd & 32'hFFF);
            default: r = p1;
        endcase
        return 12'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_pc    = '0;
            m_insn  = '0;
            m_count = '0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ready) begin
                m_insn  = imem_rdata;
                m_phase = 2;
            end
        end else if (exec_done) begin
            m_pc    = ref_next_pc(m_pc, m_insn, pc_sel, ilt_neq, is_ne, is_lt, rd_value,
                                  rstatus_value);
            m_count = m_count + 1;
            m_phase = 1;
        end
        #1;
        check("imem_req", 32'(imem_req), 32'(m_phase == 1));
        check("insn_valid", 32'(insn_valid), 32'(m_phase == 2));
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("pc", 32'(pc), 32'(m_pc));
        check("pc_plus1", 32'(pc_plus1), 32'(wrap12(int'(m_pc) + 1)));
        check("insn", insn, m_insn);
        check("insn_count", insn_count, m_count);
    endtask

    // Fetch one word (after 'delay' not-ready cycles) and retire it with the given next-PC inputs.
    task automatic run_insn(input logic [31:0] w, input logic [2:0] sel, input logic ilt,
                            input logic ne, input logic lt, input logic [31:0] rd,
                            input logic [31:0] rs, input int delay);
        int guard;
        guard = 0;
        while (m_phase != 1 && guard < 10) begin
            cycle();
            guard++;
        end
        check("reach_fetch_timeout", 32'(m_phase == 1), 32'd1);
        imem_ready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            imem_rdata = $urandom;
            cycle();
            check("fetch_wait_req", 32'(imem_req), 32'd1);
        end
        imem_rdata = w;
        imem_ready = 1'b1;
        cycle();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("captured_insn", insn, w);
        pc_sel        = sel;
        ilt_neq       = ilt;
        is_ne         = ne;
        is_lt         = lt;
        rd_value      = rd;
        rstatus_value = rs;
        exec_done     = 1'b1;
        cycle();
        exec_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_count", insn_count, 32'd0);
        rst = 1'b0;
        imem_ready = 1'b1;
        cycle();
        imem_ready = 1'b0;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", 32'(imem_addr), 32'd0);

        run_insn(32'd10, 3'd0, 0, 0, 0, 0, 0, 0);
        check("jump_10", 32'(pc), 32'd10);
        check("count_1", insn_count, 32'd1);
        run_insn(32'h0001_FFFD, 3'd3, 1, 1, 0, 0, 0, 0);
        check("bne_taken", 32'(pc), 32'd8);
        run_insn(32'd10, 3'd0, 0, 0, 0, 0, 0, 0);
        run_insn(32'h0001_FFFD, 3'd3, 1, 0, 1, 0, 0, 5);
        check("bne_not_taken", 32'(pc), 32'd11);
        run_insn(32'd10, 3'd0, 0, 0, 0, 0, 0, 0);
        run_insn(32'h0000_0004, 3'd3, 0, 0, 1, 0, 0, 1);
        check("blt_taken", 32'(pc), 32'd15);
        run_insn(32'd20, 3'd0, 0, 0, 0, 0, 0, 0);
        run_insn(32'hF800_0123, 3'd0, 0, 0, 0, 0, 0, 2);
        check("jump_123", 32'(pc), 32'h123);
        run_insn(32'd20, 3'd0, 0, 0, 0, 0, 0, 0);
        run_insn(32'h0000_0456, 3'd1, 0, 0, 0, 0, 32'd0, 0);
        check("bex_not_taken", 32'(pc), 32'd21);
        run_insn(32'd20, 3'd0, 0, 0, 0, 0, 0, 0);
        run_insn(32'h0000_0456, 3'd1, 0, 0, 0, 0, 32'd7, 0);
        check("bex_taken", 32'(pc), 32'h456);
        run_insn(32'h0000_0000, 3'd5, 0, 0, 0, 32'h0001_F00F, 0, 0);
        check("jr", 32'(pc), 32'h00F);
        run_insn(32'h0000_0FFF, 3'd0, 0, 0, 0, 0, 0, 0);
        check("pc_fff", 32'(pc), 32'hFFF);
        check("pc_plus1_wrap", 32'(pc_plus1), 32'd0);
        run_insn(32'h1234_5678, 3'd2, 0, 0, 0, 0, 0, 0);
        check("seq_wrap", 32'(pc), 32'd0);
        run_insn(32'h0000_0077, 3'd6, 1, 1, 1, 32'hABC, 32'd1, 0);
        check("undef_sel", 32'(pc), 32'd1);
        check("count_16", insn_count, 32'd16);

        // Reset while holding an instruction with exec_done asserted the same cycle.
        imem_rdata = 32'h0000_0055;
        imem_ready = 1'b1;
        cycle();
        imem_ready = 1'b0;
        check("pre_reset_valid", 32'(insn_valid), 32'd1);
        rst       = 1'b1;
        exec_done = 1'b1;
        pc_sel    = 3'd0;
        cycle();
        rst       = 1'b0;
        exec_done = 1'b0;
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_valid", 32'(insn_valid), 32'd0);
        check("mid_rst_count", insn_count, 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        cycle();
        check("post_rst_req", 32'(imem_req), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            imem_ready    = 1'($urandom_range(0, 1));
            imem_rdata    = $urandom;
            exec_done     = ($urandom_range(0, 2) == 0);
            pc_sel        = 3'($urandom_range(0, 7));
            ilt_neq       = 1'($urandom_range(0, 1));
            is_ne         = 1'($urandom_range(0, 1));
            is_lt         = 1'($urandom_range(0, 1));
            rd_value      = $urandom;
            rstatus_value = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            cycle();
        end
        rst = 1'b0;
        exec_done = 1'b0;
        imem_ready = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
